mont_mul_cios: RTL
==================

Name: mont_mul_cios

Overview:
- Word-serial Montgomery multiplier computing A·B·2^(-32n) mod N with the CIOS method (radix 2^32).
- Operand length n is selected at run time, up to MAX_WORDS.
- Operands are fetched and the result written back through the core's LSU port, with the same handshake as the existing bit-serial multiplier.
- Adds a square mode, error reporting, and a single 32x32 multiplier datapath instead of a full-width adder.

Parameters:
- MAX_WORDS, 8: maximum operand length in 32-bit words. Power of two, ≥2.
- N_WIDTH, $clog2(MAX_WORDS)+1: width of n_words.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous, active-low.
- start  in  1  one-cycle pulse to begin an operation; ignored while busy.
- mode  in  1  0 = MUL (A·B), 1 = SQR (A·A). Sampled at start.
- n_words  in  N_WIDTH  operand length n. Sampled at start.
- n0_inv  in  32  value −N^(-1) mod 2^32. Sampled at start.
- lsu_ren  out  1  read request.
- lsu_wen  out  1  write request.
- lsu_type  out  2  fixed at DATA_WORD.
- lsu_addr_offset  out  32  byte offset, equal to word index ×4.
- lsu_done  in  1  LSU completion strobe.
- lsu_rdata  in  32  read data.
- lsu_wdata  out  32  write data.
- op_address_sel  out  2  base select: 0 = A, 1 = B, 2 = N, 3 = result.
- busy  out  1  high from the cycle after an accepted start until the cycle after done.
- done  out  1  one-cycle completion pulse.
- error  out  1  valid with done. High if n_words is 0 or greater than MAX_WORDS.

Behaviour:
- Reset values: all outputs 0. Internal state: CS = IDLE, counters 0, T array 0, A/B/N arrays 0.
- Reset mid-operation aborts immediately. No further LSU requests are issued.
- States: IDLE, CHECK, FETCH, MUL_AB, MCALC, RED, SUB, WRITE, FINISH.
- IDLE: on start, latch mode, n_words and n0_inv; clear T[0..n+1]; go to CHECK.
- CHECK (1 cycle):
  - If n is illegal, go to FINISH with error = 1. No memory access occurs.
  - Otherwise go to FETCH.
- FETCH:
  - Read order: A[0..n-1], then B[0..n-1] (skipped when SQR; B aliases A), then N[0..n-1].
  - lsu_ren, lsu_addr_offset and op_address_sel stay stable until lsu_done.
  - The word is latched on lsu_done; the next request is issued in the following cycle.
  - Data returned with lsu_done is latched even when lsu_done arrives in the same cycle as the request.
- Outer loop i = 0..n-1, where bi = B[i]:
  - MUL_AB, n+1 cycles:
    - Cycle j < n: (C,S) = T[j] + A[j]·bi + C; T[j] = S.
    - Cycle n: (C,S) = T[n] + C; T[n] = S; T[n+1] = C.
    - C is 32 bits and is cleared at entry.
  - MCALC, 1 cycle: m = T[0]·n0_inv mod 2^32.
  - RED, n+1 cycles:
    - Cycle j = 0: (C,S) = T[0] + m·N[0]; S is discarded (it is zero by construction).
    - Cycle j in 1..n-1: (C,S) = T[j] + m·N[j] + C; T[j-1] = S.
    - Cycle n: (C,S) = T[n] + C; T[n-1] = S; T[n] = T[n+1] + C; T[n+1] = 0.
  - Compute latency per outer iteration is exactly 2n+3 cycles.
- SUB, n+1 cycles:
  - Word-serial T − {0,N} with borrow, covering T[n].
  - Records the flag ge = (final borrow == 0). Nothing is stored.
- WRITE, n words:
  - Word j is ge ? T[j] − N[j] − borrow_j : T[j], with the borrow recomputed serially from j = 0.
  - op_address_sel = 3. Each word is held until lsu_done.
- FINISH: done = 1 for 1 cycle; go to IDLE.
- Total cycles with a zero-wait LSU (lsu_done in the request cycle):
  - 1 (CHECK) + fetches + n(2n+3) + (n+1) + n + 1.
  - Fetches are 3n for MUL and 2n for SQR.
- Arithmetic rules:
  - One 32x32→64 multiplier plus a 64-bit adder: T[j] + P + C always fits in 64 bits.
  - Precondition: A, B < N and N is odd. The result is then < N.
  - Behaviour outside the precondition is undefined but must terminate.
- A start pulse arriving while busy is dropped. It does not queue.

Decomposition:
- Package mont_mul_pkg holds:
  - the state enum;
  - the op_address_sel encodings (OP_A = 0, OP_B = 1, OP_N = 2, OP_R = 3);
  - the MODE_MUL and MODE_SQR constants;
  - the shared DATA_WORD constant.
- Sub-module mont_mac32: combinational (C_out, S) = x + a·b + c_in on 32-bit inputs, instantiated once.

Test Plan:
- n=1, N=13, n0_inv=0x3B13B13B, A=1, B=1, MUL → result word 3; done pulse; error=0; 3 reads, 1 write.
- n=1, N=13, A=B=9, SQR → exactly 2 reads (op_address_sel 0 then 2), no B access; result 9.
- n=1, N=0xFFFFFFFF, n0_inv=1, A=B=0xFFFFFFFE → result 1; exercises the carry into T[1].
- n=4 and n=MAX_WORDS with random odd N and A,B<N, under random 0–5-cycle lsu_done delays → results match a reference model; addresses hold stable while waiting; compute phase takes n(2n+3) cycles.
- n_words=0 and n_words=MAX_WORDS+1 → done and error pulse in the cycle after CHECK; no lsu_ren/lsu_wen; busy drops after.
- rst_n asserted mid-RED, then a fresh start with n=1, A=B=1, N=13 → result 3; start pulses issued while busy are ignored.

Source files
------------

// File: rtl/mont_mul_pkg.sv
// Shared types and encodings for the word-serial CIOS Montgomery multiplier.
package mont_mul_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CHECK,
        FETCH,
        MUL_AB,
        MCALC,
        RED,
        SUB,
        WRITE,
        FINISH
    } state_t;

    localparam logic [1:0] OP_A = 2'd0;
    localparam logic [1:0] OP_B = 2'd1;
    localparam logic [1:0] OP_N = 2'd2;
    localparam logic [1:0] OP_R = 2'd3;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_SQR = 1'b1;

    localparam logic [1:0] DATA_WORD = 2'd2;

endpackage

// File: rtl/mont_mac32.sv
// Combinational multiply-accumulate: {c_out, s} = x + a*b + c_in, never overflows 64 bits.
module mont_mac32 (
    input  logic [31:0] x,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c_in,
    output logic [31:0] c_out,
    output logic [31:0] s
);

    logic [63:0] sum;

    always_comb begin
        sum = {32'd0, x} + ({32'd0, a} * {32'd0, b}) + {32'd0, c_in};
    end

    assign c_out = sum[63:32];
    assign s     = sum[31:0];

endmodule

// File: rtl/mont_mul_cios.sv
// Word-serial CIOS Montgomery multiplier (radix 2^32) with LSU operand fetch and result write-back.
//
// state  | meaning
// IDLE   | waiting for start; latches mode, n_words, n0_inv and clears T
// CHECK  | validate n; illegal length goes straight to FINISH with error
// FETCH  | read A, B (MUL only), N word by word over the LSU
// MUL_AB | T += A * B[i], n+1 cycles
// MCALC  | m = T[0] * n0_inv mod 2^32
// RED    | T = (T + m * N) >> 32, n+1 cycles
// SUB    | compare T against N over n+1 words, record ge
// WRITE  | write T or T - N to the result buffer
// FINISH | one-cycle done (and error) pulse
module mont_mul_cios
    import mont_mul_pkg::*;
#(
    parameter int MAX_WORDS = 8,
    parameter int N_WIDTH   = $clog2(MAX_WORDS) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               mode,
    input  logic [N_WIDTH-1:0] n_words,
    input  logic [31:0]        n0_inv,
    output logic               lsu_ren,
    output logic               lsu_wen,
    output logic [1:0]         lsu_type,
    output logic [31:0]        lsu_addr_offset,
    input  logic               lsu_done,
    input  logic [31:0]        lsu_rdata,
    output logic [31:0]        lsu_wdata,
    output logic [1:0]         op_address_sel,
    output logic               busy,
    output logic               done,
    output logic               error
);

    localparam int AW = $clog2(MAX_WORDS);
    localparam int TW = MAX_WORDS + 2;

    state_t state, state_nx;

    logic               mode_r;
    logic [N_WIDTH-1:0] n_r;
    logic [31:0]        n0_inv_r;
    logic               err_r;
    logic [N_WIDTH-1:0] j;
    logic [N_WIDTH-1:0] i;
    logic [1:0]         fsel;
    logic [31:0]        carry;
    logic [31:0]        m_r;
    logic               borrow;
    logic               ge;

    logic [31:0] a_mem [MAX_WORDS];
    logic [31:0] b_mem [MAX_WORDS];
    logic [31:0] n_mem [MAX_WORDS];
    logic [31:0] t_mem [TW];

    logic [N_WIDTH-1:0] n_last, n_p1, j_m1;
    logic [AW-1:0]      ja, ia;
    logic               j_last, j_end, i_last, n_bad;
    logic [31:0]        bi, t_j;
    logic [31:0]        mac_x, mac_a, mac_b, mac_c, mac_cout, mac_s;
    logic [31:0]        sub_n;
    logic [32:0]        sub_full;
    logic               sub_borrow;

    assign n_last = n_r - N_WIDTH'(1);
    assign n_p1   = n_r + N_WIDTH'(1);
    assign j_m1   = j - N_WIDTH'(1);
    assign ja     = j[AW-1:0];
    assign ia     = i[AW-1:0];
    assign j_last = (j == n_last);
    assign j_end  = (j == n_r);
    assign i_last = (i == n_last);
    assign n_bad  = (n_r == '0) || (n_r > N_WIDTH'(MAX_WORDS));
    assign t_j    = t_mem[j];
    // In square mode the B operand is never fetched; A stands in for it.
    assign bi     = (mode_r == MODE_SQR) ? a_mem[ia] : b_mem[ia];

    always_comb begin
        mac_x = '0;
        mac_a = '0;
        mac_b = '0;
        mac_c = '0;
        case (state)
            MUL_AB: begin
                mac_x = t_j;
                mac_c = carry;
                if (!j_end) begin
                    mac_a = a_mem[ja];
                    mac_b = bi;
                end
            end
            MCALC: begin
                mac_a = t_mem[0];
                mac_b = n0_inv_r;
            end
            RED: begin
                mac_x = t_j;
                mac_c = carry;
                if (!j_end) begin
                    mac_a = m_r;
                    mac_b = n_mem[ja];
                end
            end
            default: ;
        endcase
    end

    mont_mac32 u_mac (
        .x     (mac_x),
        .a     (mac_a),
        .b     (mac_b),
        .c_in  (mac_c),
        .c_out (mac_cout),
        .s     (mac_s)
    );

    // Shared by SUB (compare only) and WRITE (recomputes the same borrow chain).
    assign sub_n      = j_end ? 32'd0 : n_mem[ja];
    assign sub_full   = {1'b0, t_j} - {1'b0, sub_n} - {32'd0, borrow};
    assign sub_borrow = sub_full[32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx        = state;
        lsu_ren         = 1'b0;
        lsu_wen         = 1'b0;
        lsu_type        = 2'd0;
        lsu_addr_offset = '0;
        lsu_wdata       = '0;
        op_address_sel  = OP_A;
        busy            = (state != IDLE);
        done            = 1'b0;
        error           = 1'b0;
        case (state)
            IDLE:   if (start) state_nx = CHECK;
            CHECK:  state_nx = n_bad ? FINISH : FETCH;
            FETCH: begin
                lsu_ren         = 1'b1;
                lsu_type        = DATA_WORD;
                lsu_addr_offset = {{(30-N_WIDTH){1'b0}}, j, 2'b00};
                op_address_sel  = fsel;
                if (lsu_done && j_last && fsel == OP_N) state_nx = MUL_AB;
            end
            MUL_AB: if (j_end) state_nx = MCALC;
            MCALC:  state_nx = RED;
            RED:    if (j_end) state_nx = i_last ? SUB : MUL_AB;
            SUB:    if (j_end) state_nx = WRITE;
            WRITE: begin
                lsu_wen         = 1'b1;
                lsu_type        = DATA_WORD;
                lsu_addr_offset = {{(30-N_WIDTH){1'b0}}, j, 2'b00};
                op_address_sel  = OP_R;
                lsu_wdata       = ge ? sub_full[31:0] : t_j;
                if (lsu_done && j_last) state_nx = FINISH;
            end
            FINISH: begin
                done     = 1'b1;
                error    = err_r;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r   <= MODE_MUL;
            n_r      <= '0;
            n0_inv_r <= '0;
            err_r    <= 1'b0;
            j        <= '0;
            i        <= '0;
            fsel     <= OP_A;
            carry    <= '0;
            m_r      <= '0;
            borrow   <= 1'b0;
            ge       <= 1'b0;
            for (int k = 0; k < MAX_WORDS; k++) begin
                a_mem[k] <= '0;
                b_mem[k] <= '0;
                n_mem[k] <= '0;
            end
            for (int k = 0; k < TW; k++) t_mem[k] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_r   <= mode;
                        n_r      <= n_words;
                        n0_inv_r <= n0_inv;
                        j        <= '0;
                        i        <= '0;
                        fsel     <= OP_A;
                        carry    <= '0;
                        borrow   <= 1'b0;
                        for (int k = 0; k < TW; k++) t_mem[k] <= '0;
                    end
                end
                CHECK: err_r <= n_bad;
                FETCH: begin
                    if (lsu_done) begin
                        case (fsel)
                            OP_A:    a_mem[ja] <= lsu_rdata;
                            OP_B:    b_mem[ja] <= lsu_rdata;
                            default: n_mem[ja] <= lsu_rdata;
                        endcase
                        if (j_last) begin
                            j <= '0;
                            carry <= '0;
                            if (fsel == OP_A)
                                fsel <= (mode_r == MODE_SQR) ? OP_N : OP_B;
                            else
                                fsel <= OP_N;
                        end else begin
                            j <= j + N_WIDTH'(1);
                        end
                    end
                end
                MUL_AB: begin
                    if (!j_end) begin
                        t_mem[j] <= mac_s;
                        carry    <= mac_cout;
                        j        <= j + N_WIDTH'(1);
                    end else begin
                        t_mem[n_r]  <= mac_s;
                        t_mem[n_p1] <= mac_cout;
                        j           <= '0;
                    end
                end
                MCALC: begin
                    m_r   <= mac_s;
                    carry <= '0;
                end
                RED: begin
                    if (j == '0) begin
                        carry <= mac_cout;
                        j     <= j + N_WIDTH'(1);
                    end else if (!j_end) begin
                        t_mem[j_m1] <= mac_s;
                        carry       <= mac_cout;
                        j           <= j + N_WIDTH'(1);
                    end else begin
                        t_mem[n_last] <= mac_s;
                        t_mem[n_r]    <= t_mem[n_p1] + mac_cout;
                        t_mem[n_p1]   <= '0;
                        carry         <= '0;
                        j             <= '0;
                        borrow        <= 1'b0;
                        i             <= i_last ? '0 : i + N_WIDTH'(1);
                    end
                end
                SUB: begin
                    if (j_end) begin
                        ge     <= ~sub_borrow;
                        borrow <= 1'b0;
                        j      <= '0;
                    end else begin
                        borrow <= sub_borrow;
                        j      <= j + N_WIDTH'(1);
                    end
                end
                WRITE: begin
                    if (lsu_done) begin
                        borrow <= sub_borrow;
                        j      <= j_last ? '0 : j + N_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
